// File: rtl/keccak_arbiter.sv
// keccak_arbiter: round-robin owner of a single 512-bit keccak core.
// One requester holds the core for a whole message; the core is cleared
// before each message and the resulting digest is returned tagged with the
// index of the requester that produced it.
module keccak_arbiter #(
    parameter int unsigned N   = 2,
    parameter int unsigned IDW = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req_valid,
    input  logic [32*N-1:0]  req_in,
    input  logic [N-1:0]     req_last,
    input  logic [2*N-1:0]   req_byte_num,
    output logic [N-1:0]     req_ready,
    output logic             core_reset,
    output logic [31:0]      core_in,
    output logic             core_in_ready,
    output logic             core_is_last,
    output logic [1:0]       core_byte_num,
    input  logic             core_buffer_full,
    input  logic [511:0]     core_out,
    input  logic             core_out_ready,
    output logic [511:0]     digest,
    output logic [IDW-1:0]   digest_id,
    output logic             digest_valid,
    output logic             busy,
    output logic [IDW-1:0]   grant_id
);

    typedef enum logic [2:0] {
        StIdle,
        StClr,
        StFeed,
        StWait,
        StDone
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] grant_q, grant_d;
    logic [511:0]   digest_q;
    logic [IDW-1:0] digest_id_q;
    logic           digest_valid_q;
    logic           core_reset_q;

    logic           sel_valid;
    logic           sel_last;
    logic [31:0]    sel_in;
    logic [1:0]     sel_bn;
    logic           feed;
    logic           accept;
    logic           found;
    int unsigned    pick;

    // Select the lane currently owning the core.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_in    = '0;
        sel_bn    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(grant_q) == k) begin
                sel_valid = req_valid[k];
                sel_last  = req_last[k];
                sel_in    = req_in[32*k +: 32];
                sel_bn    = req_byte_num[2*k +: 2];
            end
        end
    end

    assign feed   = (state_q == StFeed);
    assign accept = feed & sel_valid & ~core_buffer_full;

    // Next-state logic; the grant search scans from ptr upward, then wraps to 0.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        found   = 1'b0;
        pick    = 0;
        unique case (state_q)
            StIdle: begin
                for (int unsigned k = 0; k < N; k++) begin
                    if (!found && req_valid[k] && (k >= 32'(ptr_q))) begin
                        found = 1'b1;
                        pick  = k;
                    end
                end
                for (int unsigned k = 0; k < N; k++) begin
                    if (!found && req_valid[k]) begin
                        found = 1'b1;
                        pick  = k;
                    end
                end
                if (found) begin
                    grant_d = IDW'(pick);
                    state_d = StClr;
                end
            end
            StClr: state_d = StFeed;
            StFeed: begin
                if (accept && sel_last) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (core_out_ready) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                ptr_d   = (32'(grant_q) == N - 1) ? '0 : grant_q + 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and registered outputs; the core is held cleared during reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            ptr_q          <= '0;
            grant_q        <= '0;
            digest_q       <= '0;
            digest_id_q    <= '0;
            digest_valid_q <= 1'b0;
            core_reset_q   <= 1'b1;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            grant_q        <= grant_d;
            core_reset_q   <= (state_d == StClr);
            digest_valid_q <= (state_d == StDone);
            // Capture on entry to DONE so digest is stable while digest_valid pulses.
            if (state_q == StWait && core_out_ready) begin
                digest_q    <= core_out;
                digest_id_q <= grant_q;
            end
        end
    end

    // Ready goes only to the owning lane, and only when a word actually moves.
    always_comb begin
        req_ready = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (32'(grant_q) == k) begin
                req_ready[k] = accept;
            end
        end
    end

    assign core_in_ready = accept;
    assign core_in       = feed ? sel_in : '0;
    assign core_is_last  = feed & sel_last;
    assign core_byte_num = feed ? sel_bn : 2'b00;
    assign core_reset    = core_reset_q;
    assign digest        = digest_q;
    assign digest_id     = digest_id_q;
    assign digest_valid  = digest_valid_q;
    assign busy          = (state_q != StIdle);
    assign grant_id      = grant_q;

endmodule

// File: tb/tb_keccak_arbiter.sv
// Bench for keccak_arbiter: a stand-in core with random back-pressure and
// latency, directed empty-message and mid-message reset cases, then random
// multi-lane traffic checked against a message-level round-robin model.
module tb_keccak_arbiter;

    localparam int unsigned N    = 3;
    localparam int unsigned IDW  = 2;
    localparam int unsigned MAXW = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [32*N-1:0]   req_in;
    logic [N-1:0]      req_last;
    logic [2*N-1:0]    req_byte_num;
    logic [N-1:0]      req_ready;
    logic              core_reset;
    logic [31:0]       core_in;
    logic              core_in_ready;
    logic              core_is_last;
    logic [1:0]        core_byte_num;
    logic              core_buffer_full = 1'b0;
    logic [511:0]      core_out;
    logic              core_out_ready = 1'b0;
    logic [511:0]      digest;
    logic [IDW-1:0]    digest_id;
    logic              digest_valid;
    logic              busy;
    logic [IDW-1:0]    grant_id;

    keccak_arbiter #(.N(N), .IDW(IDW)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_in           (req_in),
        .req_last         (req_last),
        .req_byte_num     (req_byte_num),
        .req_ready        (req_ready),
        .core_reset       (core_reset),
        .core_in          (core_in),
        .core_in_ready    (core_in_ready),
        .core_is_last     (core_is_last),
        .core_byte_num    (core_byte_num),
        .core_buffer_full (core_buffer_full),
        .core_out         (core_out),
        .core_out_ready   (core_out_ready),
        .digest           (digest),
        .digest_id        (digest_id),
        .digest_valid     (digest_valid),
        .busy             (busy),
        .grant_id         (grant_id)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Stand-in hash: order sensitive, ignores the data of a zero-byte final word.
    function automatic logic [31:0] mix(input logic [31:0] h, input logic [31:0] w,
                                        input logic last, input logic [1:0] bn);
        if (last && bn == 2'd0) return h;
        return ((h ^ w) * 32'h0100_0193) + {30'd0, bn};
    endfunction

    function automatic logic [511:0] digest_of(input logic [31:0] h, input logic [7:0] cnt);
        return {32'h0eab_42de ^ h, {15{h ^ {24'd0, cnt}}}};
    endfunction

    function automatic int unsigned first_from(input int unsigned p, input logic [N-1:0] v);
        for (int unsigned i = 0; i < N; i++) begin
            if (v[(p + i) % N]) return (p + i) % N;
        end
        return 0;
    endfunction

    // Stand-in keccak core.
    logic        sh_reset = 1'b1;
    logic        sh_ready = 1'b0;
    logic        sh_last  = 1'b0;
    logic [31:0] sh_in    = '0;
    logic [1:0]  sh_bn    = '0;
    logic [31:0] acc      = '0;
    logic [7:0]  cnt      = '0;
    logic        pend     = 1'b0;
    int unsigned dly      = 0;
    int unsigned bp_cnt   = 0;
    bit          bp_en    = 1'b0;

    always @(negedge clk) begin
        #2;
        sh_reset <= core_reset;
        sh_ready <= core_in_ready;
        sh_last  <= core_is_last;
        sh_in    <= core_in;
        sh_bn    <= core_byte_num;
    end

    always @(posedge clk) begin
        if (sh_reset) begin
            acc            <= '0;
            cnt            <= '0;
            pend           <= 1'b0;
            dly            <= 0;
            core_out_ready <= 1'b0;
        end else begin
            if (sh_ready) begin
                acc <= mix(acc, sh_in, sh_last, sh_last ? sh_bn : 2'd0);
                cnt <= cnt + 8'd1;
                if (sh_last) begin
                    pend <= 1'b1;
                    dly  <= $urandom_range(0, 3);
                end
            end
            if (pend) begin
                if (dly == 0) begin
                    core_out_ready <= 1'b1;
                    pend           <= 1'b0;
                end else begin
                    dly <= dly - 1;
                end
            end
        end
        if (bp_en && bp_cnt > 0) begin
            core_buffer_full <= 1'b1;
            bp_cnt           <= bp_cnt - 1;
        end else if (bp_en && $urandom_range(0, 11) == 0) begin
            core_buffer_full <= 1'b1;
            bp_cnt           <= $urandom_range(0, 5);
        end else begin
            core_buffer_full <= 1'b0;
        end
    end

    assign core_out = digest_of(acc, cnt);

    // Lane 0 sends the empty message; checks the CLR slot and grant latency.
    task automatic run_empty();
        int unsigned seen;
        seen = 0;
        req_valid[0]       = 1'b1;
        req_in[31:0]       = '0;
        req_last[0]        = 1'b1;
        req_byte_num[1:0]  = 2'd0;
        @(negedge clk);
        check("clr_busy", busy, 1'b1);
        check("clr_grant", grant_id, 0);
        check("clr_core_reset", core_reset, 1'b1);
        check("clr_in_ready", core_in_ready, 1'b0);
        @(negedge clk);
        check("feed_core_reset", core_reset, 1'b0);
        check("feed_in_ready", core_in_ready, 1'b1);
        check("feed_req_ready", req_ready, 3'b001);
        @(negedge clk);
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (digest_valid) begin
                seen++;
                check("empty_id", digest_id, 0);
                check("empty_top", digest[511:480], 32'h0eab_42de);
            end
        end
        check("empty_pulses", seen, 1);
        check("empty_idle", busy, 1'b0);
    endtask

    // Random-phase state.
    logic [31:0]  mw [N][MAXW];
    int unsigned  mlen [N];
    int unsigned  widx [N];
    int unsigned  gap  [N];
    logic [1:0]   mbn  [N];
    logic [31:0]  mh   [N];
    logic [31:0]  done_h [N];
    logic [7:0]   done_cnt [N];
    bit           have [N];
    logic [N-1:0] will_acc;
    logic [N-1:0] pend_dig;
    logic [N-1:0] own;
    int unsigned  msgs_left, mptr, mgrant, cyc, dv_seen;
    bit           prev_busy, in_clr, clr_now, finished, lane_busy, lastw;
    logic [31:0]  h;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        reset        = 1'b1;
        req_valid    = '0;
        req_in       = '0;
        req_last     = '0;
        req_byte_num = '0;
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_core_reset", core_reset, 1'b1);
        check("rst_req_ready", req_ready, '0);
        check("rst_in_ready", core_in_ready, 1'b0);
        check("rst_dv", digest_valid, 1'b0);
        check("rst_digest", digest, '0);
        check("rst_digest_id", digest_id, 0);
        check("rst_grant", grant_id, 0);
        reset = 1'b1;
        @(negedge clk);
        check("rel_core_reset", core_reset, 1'b0);
        check("rel_busy", busy, 1'b0);

        run_empty();

        // Abandon a message on lane 1 with an asynchronous reset during FEED.
        req_valid[1]      = 1'b1;
        req_in[63:32]     = 32'h1234_5678;
        req_last[1]       = 1'b0;
        req_byte_num[3:2] = 2'd0;
        repeat (4) @(negedge clk);
        check("mid_busy", busy, 1'b1);
        check("mid_grant", grant_id, 1);
        check("mid_feed", core_in_ready, 1'b1);
        #3 reset = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_core_reset", core_reset, 1'b1);
        check("mid_rst_req_ready", req_ready, '0);
        check("mid_rst_in_ready", core_in_ready, 1'b0);
        req_valid = '0;
        dv_seen   = 0;
        repeat (3) begin
            @(negedge clk);
            if (digest_valid) dv_seen++;
        end
        check("mid_no_digest", dv_seen, 0);
        reset = 1'b1;
        run_empty();

        // Random multi-lane traffic.
        bp_en     = 1'b1;
        msgs_left = 60;
        mptr      = 1;
        mgrant    = 0;
        prev_busy = 1'b0;
        in_clr    = 1'b0;
        finished  = 1'b0;
        will_acc  = '0;
        pend_dig  = '0;
        for (int k = 0; k < N; k++) begin
            have[k] = 1'b0;
            gap[k]  = 0;
            widx[k] = 0;
            mlen[k] = 1;
        end
        cyc = 0;
        while (!finished && cyc < 20000) begin
            cyc++;
            @(negedge clk);
            clr_now = 1'b0;
            if (!prev_busy) begin
                check("grant_busy", busy, |req_valid);
                if (|req_valid) begin
                    mgrant = first_from(mptr, req_valid);
                    check("grant_id", grant_id, mgrant);
                    check("clr_pulse", core_reset, 1'b1);
                    clr_now = 1'b1;
                end
            end else if (in_clr) begin
                check("clr_end", core_reset, 1'b0);
            end
            in_clr = clr_now;
            if (digest_valid) begin
                check("dig_id", digest_id, mgrant);
                check("dig_val", digest, digest_of(done_h[mgrant], done_cnt[mgrant]));
                check("dig_pending", pend_dig[mgrant], 1'b1);
                pend_dig[mgrant] = 1'b0;
                mptr = (mgrant + 1) % N;
            end
            for (int k = 0; k < N; k++) begin
                if (will_acc[k]) begin
                    if (widx[k] == mlen[k] - 1) begin
                        have[k]     = 1'b0;
                        done_h[k]   = mh[k];
                        done_cnt[k] = 8'(mlen[k]);
                        pend_dig[k] = 1'b1;
                    end else begin
                        widx[k]++;
                    end
                end
            end
            for (int k = 0; k < N; k++) begin
                if (!have[k] && msgs_left > 0 && $urandom_range(0, 3) == 0) begin
                    mlen[k] = $urandom_range(1, MAXW);
                    mbn[k]  = 2'($urandom_range(0, 3));
                    h       = '0;
                    for (int w = 0; w < MAXW; w++) begin
                        mw[k][w] = $urandom;
                    end
                    for (int unsigned w = 0; w < mlen[k]; w++) begin
                        lastw = (w == mlen[k] - 1);
                        h = mix(h, mw[k][w], lastw, lastw ? mbn[k] : 2'd0);
                    end
                    mh[k]   = h;
                    have[k] = 1'b1;
                    widx[k] = 0;
                    msgs_left--;
                end
            end
            for (int k = 0; k < N; k++) begin
                if (have[k]) begin
                    lastw = (widx[k] == mlen[k] - 1);
                    if (gap[k] > 0) begin
                        gap[k]--;
                        req_valid[k] = 1'b0;
                    end else if ($urandom_range(0, 9) == 0) begin
                        gap[k]       = $urandom_range(0, 2);
                        req_valid[k] = 1'b0;
                    end else begin
                        req_valid[k] = 1'b1;
                    end
                    req_in[32*k +: 32]      = mw[k][widx[k]];
                    req_last[k]             = lastw;
                    req_byte_num[2*k +: 2]  = lastw ? mbn[k] : 2'd0;
                end else begin
                    req_valid[k]            = 1'b0;
                    req_in[32*k +: 32]      = $urandom;
                    req_last[k]             = 1'($urandom);
                    req_byte_num[2*k +: 2]  = 2'($urandom);
                end
            end
            #1;
            will_acc = req_ready;
            if (core_buffer_full) begin
                check("bp_in_ready", core_in_ready, 1'b0);
                check("bp_req_ready", req_ready, '0);
            end
            if (in_clr) check("clr_no_in", core_in_ready, 1'b0);
            if (!busy) check("idle_core_in", {core_in, core_is_last, core_byte_num}, '0);
            if (busy) begin
                own = '0;
                for (int k = 0; k < N; k++) begin
                    if (grant_id == IDW'(k)) own[k] = 1'b1;
                end
                check("rdy_owner", req_ready & ~own, '0);
            end
            prev_busy = busy;
            lane_busy = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (have[k]) lane_busy = 1'b1;
            end
            if (msgs_left == 0 && !lane_busy && !busy && pend_dig == '0) finished = 1'b1;
        end
        check("timeout", finished, 1'b1);
        check("undigested", pend_dig, '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
